// File: rtl/rvb_pcpi_pkg.sv
// Shared types and constants for the PCPI initiator (rvb_pcpi_master).
package rvb_pcpi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RESULT = 2'd2
  } pcpi_state_t;

  localparam int unsigned RVB_PCPI_TIMEOUT_DEFAULT = 16;
  localparam int unsigned RVB_PCPI_TIMER_W         = 8;
  localparam int unsigned RVB_PCPI_CYCLES_W        = 16;

  // Saturating increment for the optional valid-cycle counter.
  function automatic logic [RVB_PCPI_CYCLES_W-1:0] sat_inc(
    input logic [RVB_PCPI_CYCLES_W-1:0] value
  );
    return (&value) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/rvb_pcpi_master.sv
// PCPI initiator: valid/ready command in, PCPI request out, valid/ready response back,
// with PicoRV32-style illegal-instruction timeout. Optional `RVB_PCPI_CYCLES_EN adds dout_cycles.
module rvb_pcpi_master
  import rvb_pcpi_pkg::*;
#(
  parameter int unsigned TIMEOUT = RVB_PCPI_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic [31:0] din_insn,
  input  logic [31:0] din_rs1,
  input  logic [31:0] din_rs2,
  input  logic [31:0] din_rs3,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic [31:0] dout_rd,
  output logic        dout_wr,
  output logic        dout_illegal,
  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  output logic [31:0] pcpi_rs1,
  output logic [31:0] pcpi_rs2,
  output logic [31:0] pcpi_rs3,
  input  logic        pcpi_wr,
  input  logic [31:0] pcpi_rd,
  input  logic        pcpi_wait,
  input  logic        pcpi_ready
`ifdef RVB_PCPI_CYCLES_EN
  ,
  output logic [RVB_PCPI_CYCLES_W-1:0] dout_cycles
`endif
);

  localparam logic [RVB_PCPI_TIMER_W-1:0] TIMEOUT_LAST = RVB_PCPI_TIMER_W'(TIMEOUT - 1);

  pcpi_state_t                 state, next_state;
  logic [RVB_PCPI_TIMER_W-1:0] timer;
  logic                        waited;
  logic                        ready_en;
  logic                        accept;
  logic                        timed_out;

  assign accept    = din_valid && din_ready;
  assign timed_out = !waited && (timer == TIMEOUT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  // NOTE: default assignment first so no path through the case infers a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept) next_state = ISSUE;
      ISSUE:   if (pcpi_ready || (!pcpi_wait && timed_out)) next_state = RESULT;
      RESULT:  if (dout_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // ready_en keeps din_ready low through reset and rises on the first edge after release.
  always_comb begin
    din_ready  = (state == IDLE) && ready_en;
    dout_valid = (state == RESULT);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ready_en <= 1'b0;
    else         ready_en <= 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pcpi_valid   <= 1'b0;
      pcpi_insn    <= '0;
      pcpi_rs1     <= '0;
      pcpi_rs2     <= '0;
      pcpi_rs3     <= '0;
      timer        <= '0;
      waited       <= 1'b0;
      dout_rd      <= '0;
      dout_wr      <= 1'b0;
      dout_illegal <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            pcpi_insn  <= din_insn;
            pcpi_rs1   <= din_rs1;
            pcpi_rs2   <= din_rs2;
            pcpi_rs3   <= din_rs3;
            pcpi_valid <= 1'b1;
            timer      <= '0;
            waited     <= 1'b0;
          end
        end
        ISSUE: begin
          if (pcpi_ready) begin
            dout_wr      <= pcpi_wr;
            dout_rd      <= pcpi_wr ? pcpi_rd : 32'd0;
            dout_illegal <= 1'b0;
            pcpi_valid   <= 1'b0;
          end else if (pcpi_wait) begin
            // A claimed command may run arbitrarily long; the timeout stays off from here on.
            waited <= 1'b1;
            timer  <= '0;
          end else if (timed_out) begin
            dout_illegal <= 1'b1;
            dout_wr      <= 1'b0;
            dout_rd      <= '0;
            pcpi_valid   <= 1'b0;
          end else if (!waited) begin
            timer <= timer + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RVB_PCPI_CYCLES_EN
  logic [RVB_PCPI_CYCLES_W-1:0] valid_cnt;

  // valid_cnt counts completed ISSUE cycles; the cycle that ends ISSUE adds the final one.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_cnt   <= '0;
      dout_cycles <= '0;
    end else begin
      if (accept) begin
        valid_cnt <= '0;
      end else if (state == ISSUE) begin
        valid_cnt <= sat_inc(valid_cnt);
        if (next_state == RESULT) dout_cycles <= sat_inc(valid_cnt);
      end
    end
  end
`endif

endmodule

// File: tb/tb_rvb_pcpi_master.sv
// Directed self-checking bench for rvb_pcpi_master (TIMEOUT=16); checks dout_cycles when RVB_PCPI_CYCLES_EN is set.
module tb_rvb_pcpi_master;

  logic        clk = 1'b0;
  logic        resetn;
  logic        din_valid, din_ready;
  logic [31:0] din_insn, din_rs1, din_rs2, din_rs3;
  logic        dout_valid, dout_ready;
  logic [31:0] dout_rd;
  logic        dout_wr, dout_illegal;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2, pcpi_rs3;
  logic        pcpi_wr, pcpi_wait, pcpi_ready;
  logic [31:0] pcpi_rd;
`ifdef RVB_PCPI_CYCLES_EN
  logic [15:0] dout_cycles;
`endif

  int checks   = 0;
  int failures = 0;

  rvb_pcpi_master #(.TIMEOUT(16)) dut (
    .clk(clk), .resetn(resetn),
    .din_valid(din_valid), .din_ready(din_ready),
    .din_insn(din_insn), .din_rs1(din_rs1), .din_rs2(din_rs2), .din_rs3(din_rs3),
    .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_rd(dout_rd), .dout_wr(dout_wr), .dout_illegal(dout_illegal),
    .pcpi_valid(pcpi_valid),
    .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_rs3(pcpi_rs3),
    .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready)
`ifdef RVB_PCPI_CYCLES_EN
    , .dout_cycles(dout_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  // Advance one clock and settle just past the edge for driving and sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] insn, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] rs3);
    check("issue_din_ready", {31'd0, din_ready}, 32'd1);
    din_valid = 1'b1;
    din_insn = insn; din_rs1 = rs1; din_rs2 = rs2; din_rs3 = rs3;
    step();
    din_valid = 1'b0;
  endtask

  task automatic respond(input logic wr, input logic [31:0] rd);
    pcpi_ready = 1'b1; pcpi_wr = wr; pcpi_rd = rd;
    step();
    pcpi_ready = 1'b0; pcpi_wr = 1'b0; pcpi_rd = '0; pcpi_wait = 1'b0;
  endtask

  task automatic consume();
    dout_ready = 1'b1;
    step();
    dout_ready = 1'b0;
  endtask

  int          high_cnt;
  logic [31:0] held_rd;

  initial begin
    resetn = 1'b0;
    din_valid = 1'b0; din_insn = '0; din_rs1 = '0; din_rs2 = '0; din_rs3 = '0;
    dout_ready = 1'b0;
    pcpi_wr = 1'b0; pcpi_rd = '0; pcpi_wait = 1'b0; pcpi_ready = 1'b0;

    // Reset state
    #13;
    check("rst_din_ready",  {31'd0, din_ready},  32'd0);
    check("rst_pcpi_valid", {31'd0, pcpi_valid}, 32'd0);
    check("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
    check("rst_dout_rd",    dout_rd,             32'd0);
    check("rst_pcpi_insn",  pcpi_insn,           32'd0);
    check("rst_illegal",    {31'd0, dout_illegal}, 32'd0);
    resetn = 1'b1;
    step();
    check("post_rst_din_ready", {31'd0, din_ready}, 32'd1);

    // 1: immediate responder
    issue(32'h6000_1013, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333);
    check("t1_pcpi_valid", {31'd0, pcpi_valid}, 32'd1);
    check("t1_pcpi_insn",  pcpi_insn, 32'h6000_1013);
    check("t1_pcpi_rs1",   pcpi_rs1,  32'h1111_1111);
    check("t1_pcpi_rs3",   pcpi_rs3,  32'h3333_3333);
    check("t1_din_ready",  {31'd0, din_ready},  32'd0);
    check("t1_no_dout",    {31'd0, dout_valid}, 32'd0);
    respond(1'b1, 32'hDEAD_BEEF);
    check("t1_dout_valid", {31'd0, dout_valid},   32'd1);
    check("t1_dout_rd",    dout_rd,               32'hDEAD_BEEF);
    check("t1_dout_wr",    {31'd0, dout_wr},      32'd1);
    check("t1_illegal",    {31'd0, dout_illegal}, 32'd0);
    check("t1_pcpi_drop",  {31'd0, pcpi_valid},   32'd0);
`ifdef RVB_PCPI_CYCLES_EN
    check("t1_cycles", {16'd0, dout_cycles}, 32'd1);
`endif
    consume();
    check("t1_after_hs_dout", {31'd0, dout_valid}, 32'd0);

    // 2: wait for 40 cycles, then ready
    issue(32'h4800_1033, 32'h0000_00F0, 32'h0, 32'h0);
    pcpi_wait = 1'b1;
    repeat (40) step();
    check("t2_no_timeout", {31'd0, dout_valid}, 32'd0);
    check("t2_still_valid", {31'd0, pcpi_valid}, 32'd1);
    pcpi_wait = 1'b0;
    respond(1'b1, 32'hCAFE_0001);
    check("t2_dout_valid", {31'd0, dout_valid},   32'd1);
    check("t2_dout_rd",    dout_rd,               32'hCAFE_0001);
    check("t2_illegal",    {31'd0, dout_illegal}, 32'd0);
`ifdef RVB_PCPI_CYCLES_EN
    check("t2_cycles", {16'd0, dout_cycles}, 32'd41);
`endif
    consume();

    // 2b: one wait cycle disables the timeout even after wait drops
    issue(32'h4800_2033, 32'h5, 32'h6, 32'h7);
    pcpi_wait = 1'b1;
    step();
    pcpi_wait = 1'b0;
    repeat (25) step();
    check("t2b_no_timeout", {31'd0, dout_valid}, 32'd0);
    respond(1'b1, 32'h0000_0042);
    check("t2b_dout_rd",   dout_rd,               32'h0000_0042);
    check("t2b_illegal",   {31'd0, dout_illegal}, 32'd0);
    consume();

    // 3: never claimed -> illegal after exactly 16 valid cycles
    issue(32'hFFFF_FFFF, 32'h1, 32'h2, 32'h3);
    high_cnt = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (pcpi_valid) high_cnt++;
      else break;
    end
    check("t3_valid_cycles", high_cnt, 32'd16);
    check("t3_dout_valid",   {31'd0, dout_valid},   32'd1);
    check("t3_illegal",      {31'd0, dout_illegal}, 32'd1);
    check("t3_dout_rd",      dout_rd,               32'd0);
    check("t3_dout_wr",      {31'd0, dout_wr},      32'd0);
`ifdef RVB_PCPI_CYCLES_EN
    check("t3_cycles", {16'd0, dout_cycles}, 32'd16);
`endif
    consume();

    // 4: ready without write masks rd
    issue(32'h2000_1013, 32'h9, 32'h9, 32'h9);
    respond(1'b0, 32'h1234_5678);
    check("t4_dout_wr",  {31'd0, dout_wr},      32'd0);
    check("t4_dout_rd",  dout_rd,               32'd0);
    check("t4_illegal",  {31'd0, dout_illegal}, 32'd0);
    consume();

    // 4b: wait and ready in the same cycle act as ready
    issue(32'h2000_2013, 32'h1, 32'h1, 32'h1);
    pcpi_wait = 1'b1;
    respond(1'b1, 32'h0BAD_F00D);
    check("t4b_dout_valid", {31'd0, dout_valid}, 32'd1);
    check("t4b_dout_rd",    dout_rd,             32'h0BAD_F00D);
    consume();

    // 4c: ready coinciding with timer==15 wins over the timeout
    issue(32'h2000_3013, 32'h2, 32'h2, 32'h2);
    repeat (15) step();
    check("t4c_pending", {31'd0, dout_valid}, 32'd0);
    respond(1'b1, 32'hA5A5_A5A5);
    check("t4c_illegal", {31'd0, dout_illegal}, 32'd0);
    check("t4c_dout_rd", dout_rd,               32'hA5A5_A5A5);
    check("t4c_dout_wr", {31'd0, dout_wr},      32'd1);

    // 5: response stall with a new command waiting
    din_valid = 1'b1;
    din_insn = 32'h7777_0001; din_rs1 = 32'h10; din_rs2 = 32'h20; din_rs3 = 32'h30;
    held_rd = 32'hA5A5_A5A5;
    for (int i = 0; i < 10; i++) begin
      step();
      check("t5_din_ready", {31'd0, din_ready},  32'd0);
      check("t5_dout_hold", dout_rd,             held_rd);
      check("t5_dout_vld",  {31'd0, dout_valid}, 32'd1);
    end
    dout_ready = 1'b1;
    step();
    dout_ready = 1'b0;
    check("t5_not_taken_in_hs", {31'd0, pcpi_valid}, 32'd0);
    check("t5_ready_after_hs",  {31'd0, din_ready},  32'd1);
    step();
    din_valid = 1'b0;
    check("t5_accepted",  {31'd0, pcpi_valid}, 32'd1);
    check("t5_pcpi_insn", pcpi_insn,           32'h7777_0001);
    respond(1'b1, 32'h0000_5555);
    check("t5_dout_rd", dout_rd, 32'h0000_5555);
    consume();

    // 6: reset mid-ISSUE aborts the command
    issue(32'h1357_9BDF, 32'h1, 32'h2, 32'h3);
    step();
    #2 resetn = 1'b0;
    #1;
    check("t6_valid_drop", {31'd0, pcpi_valid}, 32'd0);
    check("t6_din_ready",  {31'd0, din_ready},  32'd0);
    step();
    #3 resetn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("t6_no_dout", {31'd0, dout_valid}, 32'd0);
    end
    issue(32'h2468_ACE0, 32'h4, 32'h5, 32'h6);
    check("t6_reissue_insn", pcpi_insn, 32'h2468_ACE0);
    respond(1'b1, 32'h0000_7777);
    check("t6_dout_valid", {31'd0, dout_valid}, 32'd1);
    check("t6_dout_rd",    dout_rd,             32'h0000_7777);
    consume();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rvb_pcpi_master.md
# rvb_pcpi_master

PCPI initiator that issues bitmanip instructions to a PCPI coprocessor (e.g. the rvb_full worker behind its PCPI adapter) from a valid/ready command stream, and returns each result on a valid/ready response stream. It runs PicoRV32-style illegal-instruction detection: a command that is never claimed by `pcpi_wait` or `pcpi_ready` within a bounded window completes as illegal. It is used as the bus-side driver in standalone coprocessor test harnesses and in non-PicoRV32 integrations.

## Interface
- `TIMEOUT`, default 16: consecutive unclaimed cycles before a command is declared illegal; legal range 1..255.
- `clk`  in  1  clock; all logic is on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `din_valid`  in  1  command valid.
- `din_ready`  out  1  command accepted when both `din_valid` and `din_ready` are high.
- `din_insn`, `din_rs1`, `din_rs2`, `din_rs3`  in  32 each  instruction word and operands.
- `dout_valid`  out  1  response valid.
- `dout_ready`  in  1  response consumed when both `dout_valid` and `dout_ready` are high.
- `dout_rd`  out  32  result; 0 when `dout_wr`=0.
- `dout_wr`  out  1  coprocessor asserted `pcpi_wr`.
- `dout_illegal`  out  1  timeout occurred; no coprocessor claimed the command.
- `pcpi_valid`  out  1  PCPI request.
- `pcpi_insn`, `pcpi_rs1`, `pcpi_rs2`, `pcpi_rs3`  out  32 each  registered copies of the command.
- `pcpi_wr`, `pcpi_ready`, `pcpi_wait`  in  1 each  coprocessor responses.
- `pcpi_rd`  in  32  coprocessor result.

## Operation
- The FSM has three states: IDLE, ISSUE and RESULT.
- **IDLE**
  - `din_ready`=1.
  - On handshake: latch the command into the `pcpi_*` registers, set `pcpi_valid`<=1, clear the timer and the `waited` flag, go to ISSUE.
- **ISSUE**
  - `din_ready`=0, and `pcpi_valid` stays high. Each cycle the highest-priority matching case below applies.
  - If `pcpi_ready`: capture `dout_wr`<=`pcpi_wr`, `dout_rd`<=(`pcpi_wr` ? `pcpi_rd` : 0), `dout_illegal`<=0, `pcpi_valid`<=0, go to RESULT.
  - Else if `pcpi_wait`: set `waited`<=1 and clear the timer. Once `waited` is set, the timeout is disabled for the rest of the command, even if `pcpi_wait` later drops.
  - Else if !`waited` and timer==`TIMEOUT`-1: `dout_illegal`<=1, `dout_wr`<=0, `dout_rd`<=0, `pcpi_valid`<=0, go to RESULT.
  - Else if !`waited`: timer++.
- **RESULT**
  - `dout_valid`=1; the outputs hold stable until the handshake, then go to IDLE.
  - `din_ready`=0; no command is accepted in the same cycle as the response handshake.
- The timer width is 8 bits.

## Timing
- Reset values of all outputs: `din_ready`=0 while `resetn` is low, and 1 from the first cycle after release. All other outputs are 0, including `pcpi_*` data and `dout_*`.
- Reset is asynchronous:
  - Asserting it mid-ISSUE drops `pcpi_valid` immediately and discards the command.
  - No response is produced for a command aborted by reset.
- Latency, with the command accepted at edge N:
  - `pcpi_valid` rises after edge N.
  - If `pcpi_ready` is sampled at edge M, `dout_valid` is high from after edge M.
  - Minimum round trip: `pcpi_ready` at N+1, `dout_valid` after N+1.
- Timeout: with no claim, `pcpi_valid` is high for exactly `TIMEOUT` cycles. With `TIMEOUT`=16, `dout_valid` rises after edge N+16.
- `pcpi_ready` and the timeout in the same cycle: `pcpi_ready` wins and the response is not illegal.
- `pcpi_valid` is low in the cycle after `pcpi_ready`, so the coprocessor never sees a re-issue.
- `pcpi_wait` and `pcpi_ready` in the same cycle: treated as `pcpi_ready`.
- Throughput: one command per at least 3 cycles. `dout_ready` stalls hold RESULT indefinitely.

## Configuration
- `RVB_PCPI_CYCLES_EN` defined:
  - Adds port `dout_cycles`  out  16, the number of cycles `pcpi_valid` was high for the reported command.
  - The count saturates at 16'hFFFF, is latched on entry to RESULT, and resets to 0.
- Undefined: no port and no counter logic. All other behaviour is identical.

## Structure
- Package `rvb_pcpi_pkg`: state enum (IDLE/ISSUE/RESULT), `RVB_PCPI_TIMEOUT_DEFAULT`=16, timer width constant (8).
- Single module, no sub-module; the timer and FSM are small enough to sit inline.

## Test plan
- Responder model raises `pcpi_ready`+`pcpi_wr` with rd=32'hDEADBEEF one cycle after `pcpi_valid` -> `dout_valid` with `dout_rd`=32'hDEADBEEF, `dout_wr`=1, `dout_illegal`=0; `pcpi_valid` low the next cycle.
- Responder asserts `pcpi_wait` for 40 cycles, then `pcpi_ready`, with `TIMEOUT`=16 -> no illegal; correct result; with the macro defined, `dout_cycles`=41.
- No responder ever claims, `TIMEOUT`=16 -> `pcpi_valid` high exactly 16 cycles, then `dout_illegal`=1, `dout_rd`=0, `dout_wr`=0.
- `pcpi_ready` with `pcpi_wr`=0 and `pcpi_rd`=32'h12345678 -> `dout_wr`=0, `dout_rd`=0. Then `pcpi_ready` at exactly timer==15 -> not illegal.
- Hold `dout_ready`=0 for 10 cycles with `din_valid` high -> `din_ready` stays 0 and `dout` is stable; the next command is accepted only after the response handshake.
- Drop `resetn` mid-ISSUE -> `pcpi_valid` drops immediately and no `dout_valid` follows; after release, a new command completes normally.
